// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline constants and controller state encoding
package pipe_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h00000033;
    localparam logic [4:0]  REG_X0    = 5'd0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DRAIN    = 2'd1,
        MEM_WAIT = 2'd2
    } pipe_state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - hazard sources from the pipeline and strobes back to it
interface hazard_ctrl_if;

    logic [4:0] ifid_rs1;
    logic [4:0] ifid_rs2;
    logic       ifid_use_rs1;
    logic       ifid_use_rs2;
    logic       idex_mem_read;
    logic [4:0] idex_rd;
    logic       branch_taken;
    logic       exmem_mem_req;
    logic       dmem_ready;

    logic       pc_we;
    logic       ifid_we;
    logic       ifid_flush;
    logic       idex_we;
    logic       idex_flush;
    logic       exmem_we;
    logic       memwb_flush;

    // master: the hazard controller
    modport master (
        input  ifid_rs1, ifid_rs2, ifid_use_rs1, ifid_use_rs2,
               idex_mem_read, idex_rd, branch_taken, exmem_mem_req, dmem_ready,
        output pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, memwb_flush
    );

    // slave: the pipeline datapath
    modport slave (
        output ifid_rs1, ifid_rs2, ifid_use_rs1, ifid_use_rs2,
               idex_mem_read, idex_rd, branch_taken, exmem_mem_req, dmem_ready,
        input  pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, memwb_flush
    );

endinterface

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use comparator between ID sources and EX load rd
module hazard_detect
    import pipe_pkg::*;
(
    input  logic [4:0] ifid_rs1,
    input  logic [4:0] ifid_rs2,
    input  logic       ifid_use_rs1,
    input  logic       ifid_use_rs2,
    input  logic       idex_mem_read,
    input  logic [4:0] idex_rd,
    output logic       stall
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = ifid_use_rs1 && (ifid_rs1 == idex_rd);
    assign rs2_hit = ifid_use_rs2 && (ifid_rs2 == idex_rd);

    // x0 is hardwired zero, so a load targeting it never creates a dependency
    assign stall = idex_mem_read && (idex_rd != REG_X0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush sequencer with load-use, redirect and memory-wait handling
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    hazard_ctrl_if.master    hz,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic [CNT_W-1:0] wait_count
);

    localparam logic [2:0] DRAIN_LOAD = 3'(FLUSH_CYCLES);

    pipe_state_t state_q, state_d;
    pipe_state_t saved_q, saved_d;
    pipe_state_t eff_state;
    logic [2:0]  drain_cnt_q, drain_cnt_d;

    logic lu_hit;
    logic mem_wait;
    logic redirect;
    logic load_use;

    hazard_detect u_detect (
        .ifid_rs1      (hz.ifid_rs1),
        .ifid_rs2      (hz.ifid_rs2),
        .ifid_use_rs1  (hz.ifid_use_rs1),
        .ifid_use_rs2  (hz.ifid_use_rs2),
        .idex_mem_read (hz.idex_mem_read),
        .idex_rd       (hz.idex_rd),
        .stall         (lu_hit)
    );

    // On the release cycle of a wait the controller acts as the state it was frozen in
    assign eff_state = (state_q == MEM_WAIT) ? saved_q : state_q;
    assign mem_wait  = hz.exmem_mem_req && !hz.dmem_ready;
    assign redirect  = hz.branch_taken && !mem_wait;
    assign load_use  = (eff_state == RUN) && !mem_wait && !hz.branch_taken && lu_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            saved_q     <= RUN;
            drain_cnt_q <= 3'd0;
            stall_count <= '0;
            flush_count <= '0;
            wait_count  <= '0;
        end else begin
            state_q     <= state_d;
            saved_q     <= saved_d;
            drain_cnt_q <= drain_cnt_d;
            if (load_use) stall_count <= stall_count + 1'b1;
            if (redirect) flush_count <= flush_count + 1'b1;
            if (mem_wait) wait_count  <= wait_count + 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        saved_d     = saved_q;
        drain_cnt_d = drain_cnt_q;
        if (mem_wait) begin
            state_d = MEM_WAIT;
            if (state_q != MEM_WAIT) saved_d = state_q;
        end else if (redirect) begin
            if (FLUSH_CYCLES > 0) begin
                state_d     = DRAIN;
                drain_cnt_d = DRAIN_LOAD;
            end else begin
                state_d     = RUN;
                drain_cnt_d = 3'd0;
            end
        end else if (eff_state == DRAIN) begin
            if (drain_cnt_q <= 3'd1) begin
                state_d     = RUN;
                drain_cnt_d = 3'd0;
            end else begin
                state_d     = DRAIN;
                drain_cnt_d = drain_cnt_q - 3'd1;
            end
        end else begin
            state_d = RUN;
        end
    end

    always_comb begin
        hz.pc_we       = 1'b1;
        hz.ifid_we     = 1'b1;
        hz.idex_we     = 1'b1;
        hz.exmem_we    = 1'b1;
        hz.ifid_flush  = 1'b0;
        hz.idex_flush  = 1'b0;
        hz.memwb_flush = 1'b0;
        if (rst) begin
            hz.pc_we       = 1'b0;
            hz.ifid_we     = 1'b0;
            hz.idex_we     = 1'b0;
            hz.ifid_flush  = 1'b1;
            hz.idex_flush  = 1'b1;
            hz.memwb_flush = 1'b1;
        end else if (mem_wait) begin
            hz.pc_we       = 1'b0;
            hz.ifid_we     = 1'b0;
            hz.idex_we     = 1'b0;
            hz.exmem_we    = 1'b0;
            hz.memwb_flush = 1'b1;
        end else if (redirect) begin
            hz.ifid_flush = 1'b1;
            hz.idex_flush = 1'b1;
        end else if (eff_state == DRAIN) begin
            hz.ifid_flush = 1'b1;
        end else if (load_use) begin
            hz.pc_we      = 1'b0;
            hz.ifid_we    = 1'b0;
            hz.idex_flush = 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;
    import pipe_pkg::*;

    localparam logic [6:0] C_DEF   = 7'b1111000;
    localparam logic [6:0] C_RST   = 7'b0001111;
    localparam logic [6:0] C_WAIT  = 7'b0000001;
    localparam logic [6:0] C_REDIR = 7'b1111110;
    localparam logic [6:0] C_DRAIN = 7'b1111100;
    localparam logic [6:0] C_LU    = 7'b0011010;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] stall_count, flush_count, wait_count;
    int          checks = 0;
    int          errors = 0;
    int          exp_stall = 0, exp_flush = 0, exp_wait = 0;

    hazard_ctrl_if hz ();

    hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .hz          (hz.master),
        .stall_count (stall_count),
        .flush_count (flush_count),
        .wait_count  (wait_count)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ctl();
        return {hz.pc_we, hz.ifid_we, hz.idex_we, hz.exmem_we,
                hz.ifid_flush, hz.idex_flush, hz.memwb_flush};
    endfunction

    // inputs change 1 time unit after posedge; outputs are sampled 1 unit later
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        hz.ifid_rs1 = 5'd0; hz.ifid_rs2 = 5'd0;
        hz.ifid_use_rs1 = 1'b0; hz.ifid_use_rs2 = 1'b0;
        hz.idex_mem_read = 1'b0; hz.idex_rd = 5'd0;
        hz.branch_taken = 1'b0; hz.exmem_mem_req = 1'b0; hz.dmem_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle();
        cyc(); #1;
        checks++; if (ctl() !== C_RST) begin errors++; $display("FAIL reset_ctl got=%b exp=%b", ctl(), C_RST); end
        checks++; if (stall_count !== 0 || flush_count !== 0 || wait_count !== 0) begin
            errors++; $display("FAIL reset_cnt got=%0d/%0d/%0d exp=0/0/0", stall_count, flush_count, wait_count); end
        checks++; if (dut.state_q !== RUN) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", dut.state_q, RUN); end
        cyc(); rst = 1'b0; #1;
        checks++; if (ctl() !== C_DEF) begin errors++; $display("FAIL reset_release_ctl got=%b exp=%b", ctl(), C_DEF); end
    endtask

    task automatic test_load_use();
        cyc();
        hz.idex_mem_read = 1'b1; hz.idex_rd = 5'd5; hz.ifid_rs2 = 5'd5; hz.ifid_use_rs2 = 1'b1;
        hz.ifid_rs1 = 5'd3; hz.ifid_use_rs1 = 1'b1; #1;
        checks++; if (ctl() !== C_LU) begin errors++; $display("FAIL lu_rs2_ctl got=%b exp=%b", ctl(), C_LU); end
        exp_stall++;
        cyc(); idle(); #1;
        checks++; if (ctl() !== C_DEF) begin errors++; $display("FAIL lu_after_ctl got=%b exp=%b", ctl(), C_DEF); end
        checks++; if (stall_count !== exp_stall) begin errors++; $display("FAIL lu_count got=%0d exp=%0d", stall_count, exp_stall); end
        // a load into x0 must not stall
        hz.idex_mem_read = 1'b1; hz.idex_rd = 5'd0; hz.ifid_use_rs1 = 1'b1; hz.ifid_use_rs2 = 1'b1; #1;
        checks++; if (ctl() !== C_DEF) begin errors++; $display("FAIL lu_x0_ctl got=%b exp=%b", ctl(), C_DEF); end
        cyc();
        hz.idex_rd = 5'd7; hz.ifid_rs1 = 5'd7; hz.ifid_use_rs1 = 1'b0; hz.ifid_use_rs2 = 1'b0; #1;
        checks++; if (ctl() !== C_DEF) begin errors++; $display("FAIL lu_unused_ctl got=%b exp=%b", ctl(), C_DEF); end
        hz.ifid_use_rs1 = 1'b1; #1;
        checks++; if (ctl() !== C_LU) begin errors++; $display("FAIL lu_rs1_ctl got=%b exp=%b", ctl(), C_LU); end
        exp_stall++;
        cyc(); idle(); #1;
        checks++; if (stall_count !== exp_stall) begin errors++; $display("FAIL lu_count2 got=%0d exp=%0d", stall_count, exp_stall); end
    endtask

    task automatic test_redirect();
        hz.branch_taken = 1'b1; #1;
        checks++; if (ctl() !== C_REDIR) begin errors++; $display("FAIL redir_ctl got=%b exp=%b", ctl(), C_REDIR); end
        exp_flush++;
        cyc(); idle(); #1;
        checks++; if (dut.state_q !== DRAIN || ctl() !== C_DRAIN) begin
            errors++; $display("FAIL redir_drain state=%0d ctl=%b exp state=%0d ctl=%b", dut.state_q, ctl(), DRAIN, C_DRAIN); end
        checks++; if (flush_count !== exp_flush) begin errors++; $display("FAIL redir_count got=%0d exp=%0d", flush_count, exp_flush); end
        cyc(); #1;
        checks++; if (dut.state_q !== RUN || ctl() !== C_DEF) begin
            errors++; $display("FAIL redir_back state=%0d ctl=%b exp state=%0d ctl=%b", dut.state_q, ctl(), RUN, C_DEF); end
    endtask

    task automatic test_mem_wait();
        for (int i = 0; i < 3; i++) begin
            hz.exmem_mem_req = 1'b1; hz.dmem_ready = 1'b0; #1;
            checks++; if (ctl() !== C_WAIT) begin errors++; $display("FAIL wait_ctl%0d got=%b exp=%b", i, ctl(), C_WAIT); end
            exp_wait++;
            cyc();
        end
        checks++; if (dut.state_q !== MEM_WAIT) begin errors++; $display("FAIL wait_state got=%0d exp=%0d", dut.state_q, MEM_WAIT); end
        hz.dmem_ready = 1'b1; #1;
        checks++; if (ctl() !== C_DEF) begin errors++; $display("FAIL wait_release_ctl got=%b exp=%b", ctl(), C_DEF); end
        cyc(); idle(); #1;
        checks++; if (wait_count !== exp_wait || dut.state_q !== RUN) begin
            errors++; $display("FAIL wait_count got=%0d state=%0d exp=%0d state=%0d", wait_count, dut.state_q, exp_wait, RUN); end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 2; i++) begin
            hz.exmem_mem_req = 1'b1; hz.dmem_ready = 1'b0; hz.branch_taken = 1'b1; #1;
            checks++; if (ctl() !== C_WAIT) begin errors++; $display("FAIL sim_wait_ctl%0d got=%b exp=%b", i, ctl(), C_WAIT); end
            exp_wait++;
            cyc();
        end
        hz.dmem_ready = 1'b1; #1;
        checks++; if (ctl() !== C_REDIR) begin errors++; $display("FAIL sim_release_ctl got=%b exp=%b", ctl(), C_REDIR); end
        exp_flush++;
        cyc(); idle(); #1;
        checks++; if (flush_count !== exp_flush || wait_count !== exp_wait) begin
            errors++; $display("FAIL sim_counts got=%0d/%0d exp=%0d/%0d", flush_count, wait_count, exp_flush, exp_wait); end
        cyc(); #1;
        // load-use together with a branch: only the redirect happens
        hz.idex_mem_read = 1'b1; hz.idex_rd = 5'd9; hz.ifid_rs1 = 5'd9; hz.ifid_use_rs1 = 1'b1;
        hz.branch_taken = 1'b1; #1;
        checks++; if (ctl() !== C_REDIR) begin errors++; $display("FAIL sim_lu_br_ctl got=%b exp=%b", ctl(), C_REDIR); end
        exp_flush++;
        cyc(); hz.branch_taken = 1'b0; #1;
        checks++; if (ctl() !== C_DRAIN) begin errors++; $display("FAIL sim_lu_drain_ctl got=%b exp=%b", ctl(), C_DRAIN); end
        cyc(); idle(); #1;
        checks++; if (stall_count !== exp_stall || flush_count !== exp_flush) begin
            errors++; $display("FAIL sim_lu_counts got=%0d/%0d exp=%0d/%0d", stall_count, flush_count, exp_stall, exp_flush); end
    endtask

    task automatic test_back_to_back();
        hz.branch_taken = 1'b1; #1;
        exp_flush++;
        cyc(); #1;
        checks++; if (dut.state_q !== DRAIN || ctl() !== C_REDIR) begin
            errors++; $display("FAIL b2b_ctl state=%0d ctl=%b exp state=%0d ctl=%b", dut.state_q, ctl(), DRAIN, C_REDIR); end
        exp_flush++;
        cyc(); hz.branch_taken = 1'b0; #1;
        checks++; if (dut.drain_cnt_q !== 3'd1 || flush_count !== exp_flush || ctl() !== C_DRAIN) begin
            errors++; $display("FAIL b2b_reload cnt=%0d flush=%0d ctl=%b exp cnt=1 flush=%0d ctl=%b",
                               dut.drain_cnt_q, flush_count, ctl(), exp_flush, C_DRAIN); end
        // wait inside DRAIN freezes drain_cnt, release cycle behaves as DRAIN
        hz.exmem_mem_req = 1'b1; hz.dmem_ready = 1'b0; #1;
        checks++; if (ctl() !== C_WAIT) begin errors++; $display("FAIL b2b_wait_ctl got=%b exp=%b", ctl(), C_WAIT); end
        exp_wait++;
        cyc(); hz.dmem_ready = 1'b1; #1;
        checks++; if (dut.drain_cnt_q !== 3'd1 || ctl() !== C_DRAIN) begin
            errors++; $display("FAIL b2b_frozen cnt=%0d ctl=%b exp cnt=1 ctl=%b", dut.drain_cnt_q, ctl(), C_DRAIN); end
        cyc(); idle(); #1;
        checks++; if (dut.state_q !== RUN || ctl() !== C_DEF) begin
            errors++; $display("FAIL b2b_back state=%0d ctl=%b exp state=%0d ctl=%b", dut.state_q, ctl(), RUN, C_DEF); end
    endtask

    task automatic test_reset_mid_wait();
        hz.exmem_mem_req = 1'b1; hz.dmem_ready = 1'b0;
        cyc(); cyc();
        checks++; if (dut.state_q !== MEM_WAIT || wait_count === 0) begin
            errors++; $display("FAIL rmw_enter state=%0d wait=%0d exp state=%0d wait>0", dut.state_q, wait_count, MEM_WAIT); end
        rst = 1'b1; #1;
        checks++; if (ctl() !== C_RST) begin errors++; $display("FAIL rmw_ctl got=%b exp=%b", ctl(), C_RST); end
        cyc(); rst = 1'b0; idle(); #1;
        checks++; if (stall_count !== 0 || flush_count !== 0 || wait_count !== 0 || dut.state_q !== RUN) begin
            errors++; $display("FAIL rmw_clear got=%0d/%0d/%0d state=%0d exp=0/0/0 state=%0d",
                               stall_count, flush_count, wait_count, dut.state_q, RUN); end
        checks++; if (ctl() !== C_DEF) begin errors++; $display("FAIL rmw_default got=%b exp=%b", ctl(), C_DEF); end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_load_use();
        test_redirect();
        test_mem_wait();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout");
        $fatal(1);
    end

endmodule
